// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// IMEM_PARITY_EN (optional) enables per-byte stored even parity.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [63:0] NOP_INSTR = 64'h0;

  // Last byte of the instruction must lie inside the array; widened so pc near the top cannot wrap.
  function automatic logic addr_in_range(input logic [31:0] pc,
                                         input int unsigned depth,
                                         input int unsigned instr_bytes);
    logic [32:0] w_last;
    w_last = {1'b0, pc} + 33'(instr_bytes) - 33'd1;
    return (w_last < 33'(depth));
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// Load-port and fetch-port signal bundle for imem_loadable.
interface imem_loadable_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IW     = 16
);
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              busy;
  logic              fetch_en;
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic [IW-1:0]     instr;
  logic              instr_valid;
  logic              fault;
  logic              parity_err;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_en, stall, pc,
    input  load_ready, load_done, busy, instr, instr_valid, fault, parity_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_en, stall, pc,
    output load_ready, load_done, busy, instr, instr_valid, fault, parity_err
  );
endinterface

// File: rtl/imem_byte_array.sv
// Byte array: one write port, INSTR_BYTES combinational big-endian read bytes at pc.
// IMEM_PARITY_EN adds a stored even-parity bit per byte and a read-side mismatch flag.
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned INSTR_BYTES = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned AW          = 8
)(
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic [7:0]               i_wdata,
  input  logic [ADDR_W-1:0]        i_pc,
  output logic [INSTR_BYTES*8-1:0] o_rdata,
  output logic                     o_par_err
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned BW = 9;
`else
  localparam int unsigned BW = 8;
`endif

  logic [BW-1:0] r_mem [DEPTH];
  logic [BW-1:0] w_wword;

`ifdef IMEM_PARITY_EN
  logic [INSTR_BYTES-1:0] w_bad;
  assign w_wword   = {byte_parity(i_wdata), i_wdata};
  assign o_par_err = |w_bad;
`else
  assign w_wword   = i_wdata;
  assign o_par_err = 1'b0;
`endif

  // Single write port shared by the clear sequencer and the loader
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= w_wword;
    end
  end

  for (genvar g = 0; g < INSTR_BYTES; g++) begin : g_rd
    logic [ADDR_W:0] w_idx;
    logic [BW-1:0]   w_word;

    assign w_idx = {1'b0, i_pc} + (ADDR_W+1)'(g);

    // Out-of-range bytes read as zero; the top flags these fetches as faults anyway
    always_comb begin
      if (w_idx < (ADDR_W+1)'(DEPTH)) begin
        w_word = r_mem[w_idx[AW-1:0]];
      end else begin
        w_word = {BW{1'b0}};
      end
    end

    assign o_rdata[(INSTR_BYTES-1-g)*8 +: 8] = w_word[7:0];
`ifdef IMEM_PARITY_EN
    assign w_bad[g] = w_word[8] ^ byte_parity(w_word[7:0]);
`endif
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: power-on zero fill, streaming byte loader, registered fetch.
// Optional IMEM_PARITY_EN turns on stored parity checking (parity_err otherwise constant 0).
module imem_loadable
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned INSTR_BYTES = 2,
  parameter int unsigned ADDR_W      = 16
)(
  input  logic          clk,
  input  logic          rst,
  imem_loadable_if.slave bus
);

  localparam int unsigned IW = 8 * INSTR_BYTES;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [AW-1:0]     r_ptr;
  logic [AW-1:0]     w_ptr_nxt;
  logic              w_we;
  logic [7:0]        w_wdata;
  logic              w_beat;
  logic              w_load_end;
  logic              r_busy;
  logic              r_load_ready;
  logic              r_load_done;
  logic [IW-1:0]     r_instr;
  logic              r_instr_valid;
  logic              r_fault;
  logic              r_parity_err;
  logic [IW-1:0]     w_rdata;
  logic              w_par_bad;
  logic              w_fetch_go;
  logic              w_fault;

  assign w_beat     = (r_state == LOAD) && bus.load_valid;
  assign w_load_end = w_beat && (bus.load_last || (r_ptr == PTR_LAST));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR: begin
        if (r_ptr == PTR_LAST) w_state_nxt = READY;
        else                   w_state_nxt = CLEAR;
      end
      READY: begin
        if (bus.load_start) w_state_nxt = LOAD;
        else                w_state_nxt = READY;
      end
      LOAD: begin
        if (w_load_end) w_state_nxt = READY;
        else            w_state_nxt = LOAD;
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Write port and pointer control
  always_comb begin
    w_we      = 1'b0;
    w_wdata   = 8'h00;
    w_ptr_nxt = r_ptr;
    case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_wdata = 8'h00;
        if (r_ptr == PTR_LAST) w_ptr_nxt = {AW{1'b0}};
        else                   w_ptr_nxt = r_ptr + AW'(1);
      end
      READY: begin
        w_ptr_nxt = {AW{1'b0}};
      end
      LOAD: begin
        w_we    = w_beat;
        w_wdata = bus.load_data;
        if (w_load_end)  w_ptr_nxt = {AW{1'b0}};
        else if (w_beat) w_ptr_nxt = r_ptr + AW'(1);
        else             w_ptr_nxt = r_ptr;
      end
      default: begin
        w_ptr_nxt = {AW{1'b0}};
      end
    endcase
  end

  // Pointer and loader status flags track the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= {AW{1'b0}};
      r_busy       <= 1'b1;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_busy       <= (w_state_nxt != READY);
      r_load_ready <= (w_state_nxt == LOAD);
      r_load_done  <= w_load_end;
    end
  end

  // A load request in the same cycle wins over the fetch
  assign w_fetch_go = (r_state == READY) && bus.fetch_en && !bus.load_start;
  assign w_fault    = ((bus.pc % ADDR_W'(INSTR_BYTES)) != {ADDR_W{1'b0}}) ||
                      !addr_in_range(32'(bus.pc), DEPTH, INSTR_BYTES);

  // Fetch output registers; stall freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr       <= NOP_INSTR[IW-1:0];
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_parity_err  <= 1'b0;
    end else if (bus.stall) begin
      r_instr       <= r_instr;
      r_instr_valid <= r_instr_valid;
      r_fault       <= r_fault;
      r_parity_err  <= r_parity_err;
    end else if (w_fetch_go) begin
      r_instr_valid <= 1'b1;
      if (w_fault) begin
        r_instr      <= NOP_INSTR[IW-1:0];
        r_fault      <= 1'b1;
        r_parity_err <= 1'b0;
      end else if (w_par_bad) begin
        r_instr      <= NOP_INSTR[IW-1:0];
        r_fault      <= 1'b0;
        r_parity_err <= 1'b1;
      end else begin
        r_instr      <= w_rdata;
        r_fault      <= 1'b0;
        r_parity_err <= 1'b0;
      end
    end else begin
      r_instr       <= r_instr;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_parity_err  <= 1'b0;
    end
  end

  imem_byte_array #(
    .DEPTH       (DEPTH),
    .INSTR_BYTES (INSTR_BYTES),
    .ADDR_W      (ADDR_W),
    .AW          (AW)
  ) u_array (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (r_ptr),
    .i_wdata   (w_wdata),
    .i_pc      (bus.pc),
    .o_rdata   (w_rdata),
    .o_par_err (w_par_bad)
  );

  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fault       = r_fault;
  assign bus.parity_err  = r_parity_err;
  assign bus.load_ready  = r_load_ready;
  assign bus.load_done   = r_load_done;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed, table-driven bench for imem_loadable (DEPTH=256, INSTR_BYTES=2, ADDR_W=16).
module tb_imem_loadable;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  imem_loadable_if #(.ADDR_W(16), .IW(16)) bus ();

  imem_loadable #(
    .DEPTH       (256),
    .INSTR_BYTES (2),
    .ADDR_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fe;
    logic        stall;
    logic [15:0] pc;
    logic        ev;
    logic [15:0] ei;
    logic        ef;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(output int n, output logic saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (bus.busy === 1'b1 && n < 2000) begin
      if (bus.instr_valid !== 1'b0) saw_valid = 1'b1;
      tick();
      n++;
    end
  endtask

  initial begin
    int   n;
    logic sv;
    errors = 0;
    checks = 0;
    rst            = 1'b1;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;
    bus.fetch_en   = 1'b1;
    bus.stall      = 1'b0;
    bus.pc         = 16'h0000;
    #1;
    chk("rst_instr",      32'(bus.instr),       32'h0);
    chk("rst_valid",      32'(bus.instr_valid), 32'h0);
    chk("rst_fault",      32'(bus.fault),       32'h0);
    chk("rst_parity",     32'(bus.parity_err),  32'h0);
    chk("rst_load_ready", 32'(bus.load_ready),  32'h0);
    chk("rst_load_done",  32'(bus.load_done),   32'h0);
    chk("rst_busy",       32'(bus.busy),        32'h1);

    // Power-on clear: busy for exactly DEPTH cycles, fetches ignored
    tick();
    tick();
    rst = 1'b0;
    wait_ready(n, sv);
    chk("clear_cycles", 32'(n), 32'd256);
    chk("clear_no_valid", 32'(sv), 32'h0);
    tick();
    chk("first_valid", 32'(bus.instr_valid), 32'h1);
    chk("first_instr", 32'(bus.instr), 32'h0000);

    // Load four bytes, last flagged on the fourth beat
    bus.fetch_en   = 1'b0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    chk("load_ready_up", 32'(bus.load_ready), 32'h1);
    chk("load_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = (i < 2) ? 8'h10 : ((i == 2) ? 8'h60 : 8'h02);
      bus.load_last  = (i == 3);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("load_done_pulse", 32'(bus.load_done), 32'h1);
    chk("load_ready_down", 32'(bus.load_ready), 32'h0);
    chk("load_idle", 32'(bus.busy), 32'h0);
    bus.fetch_en = 1'b1;
    bus.pc       = 16'h0002;
    tick();
    chk("load_done_1cyc", 32'(bus.load_done), 32'h0);
    chk("ral_valid", 32'(bus.instr_valid), 32'h1);
    chk("ral_instr", 32'(bus.instr), 32'h6002);

    // Fetch vectors: {fetch_en, stall, pc, exp_valid, exp_instr, exp_fault}
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1010, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'h6002, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h6002, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h6002, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'h00FE, 1'b1, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1010, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 16'h00FF, 1'b1, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1010, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h0100, 1'b1, 16'h0000, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'h6002, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 16'hFFFE, 1'b1, 16'h0000, 1'b1};
    for (int i = 0; i < 14; i++) begin
      bus.fetch_en = vecs[i].fe;
      bus.stall    = vecs[i].stall;
      bus.pc       = vecs[i].pc;
      tick();
      chk($sformatf("vec%0d.valid", i), 32'(bus.instr_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d.instr", i), 32'(bus.instr),       32'(vecs[i].ei));
      chk($sformatf("vec%0d.fault", i), 32'(bus.fault),       32'(vecs[i].ef));
      chk($sformatf("vec%0d.perr", i),  32'(bus.parity_err),  32'h0);
    end

    // Stall holds the previous result while pc moves
    bus.stall    = 1'b0;
    bus.fetch_en = 1'b1;
    bus.pc       = 16'h0000;
    tick();
    chk("stall_pre", 32'(bus.instr), 32'h1010);
    bus.stall = 1'b1;
    bus.pc    = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_hold%0d", i), 32'(bus.instr), 32'h1010);
      chk($sformatf("stall_vld%0d", i), 32'(bus.instr_valid), 32'h1);
    end
    bus.stall = 1'b0;
    tick();
    chk("stall_release", 32'(bus.instr), 32'h6002);

    // Load request beats a same-cycle fetch
    bus.load_start = 1'b1;
    bus.fetch_en   = 1'b1;
    bus.pc         = 16'h0000;
    tick();
    bus.load_start = 1'b0;
    bus.fetch_en   = 1'b0;
    chk("collide_valid", 32'(bus.instr_valid), 32'h0);
    chk("collide_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = (i == 0) ? 8'hAA : 8'hBB;
      tick();
    end
    bus.load_valid = 1'b0;

    // Reset mid-load returns to CLEAR and re-zeroes the array
    rst = 1'b1;
    #1;
    chk("midload_rst_busy", 32'(bus.busy), 32'h1);
    chk("midload_rst_ready", 32'(bus.load_ready), 32'h0);
    tick();
    rst = 1'b0;
    wait_ready(n, sv);
    chk("reclear_cycles", 32'(n), 32'd256);
    bus.fetch_en = 1'b1;
    bus.pc       = 16'h0000;
    tick();
    chk("reclear_mem0", 32'(bus.instr), 32'h0000);
    chk("reclear_mem0_vld", 32'(bus.instr_valid), 32'h1);
    bus.pc = 16'h0002;
`ifdef IMEM_PARITY_EN
    dut.u_array.r_mem[2] = dut.u_array.r_mem[2] ^ 9'h001;
`endif
    tick();
`ifdef IMEM_PARITY_EN
    chk("parity_err", 32'(bus.parity_err), 32'h1);
`else
    chk("parity_err", 32'(bus.parity_err), 32'h0);
`endif
    chk("parity_instr", 32'(bus.instr), 32'h0000);
    chk("parity_valid", 32'(bus.instr_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
